// File: rtl/fpu_pkg.sv
// Shared binary32 field definitions and classification helpers for the FPU units.
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] CANON_NAN = 32'hFFC0_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float32_t;

  function automatic logic is_nan(input float32_t f);
    return (f.exp == EXP_MAX) && (f.man != '0);
  endfunction

  function automatic logic is_inf(input float32_t f);
    return (f.exp == EXP_MAX) && (f.man == '0);
  endfunction

  function automatic logic is_zero(input float32_t f);
    return (f.exp == '0) && (f.man == '0);
  endfunction
endpackage

// File: rtl/fpu_lzc24.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module fpu_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  count
);
  always_comb begin
    count = 5'd24;
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < 24; i++) begin
      if (din[i]) count = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fpu_fadd.sv
// Binary32 adder, round-to-nearest-even with subnormals; single-cycle datapath
// feeding an output register.
module fpu_fadd
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);
  float32_t    f1, f2, fa, fb;
  logic        swap, sub, rnd, hid;
  logic [7:0]  ea, eb, d, lim, sh;
  logic [23:0] ma, mb;
  logic [49:0] wide;
  logic [26:0] a_al, b_al, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  exp_n, exp_r;
  logic [24:0] mant_r;
  logic [22:0] frac;
  logic [31:0] fin, res;
  logic        ovf_d;

  assign f1   = x1;
  assign f2   = x2;
  assign swap = (x2[30:0] > x1[30:0]);
  assign fa   = swap ? f2 : f1;
  assign fb   = swap ? f1 : f2;

  assign ea = (fa.exp == 8'd0) ? 8'd1 : fa.exp;
  assign eb = (fb.exp == 8'd0) ? 8'd1 : fb.exp;
  assign ma = {fa.exp != 8'd0, fa.man};
  assign mb = {fb.exp != 8'd0, fb.man};
  assign d  = ea - eb;

  // Smaller operand gets guard/round bits plus a sticky OR of everything shifted out.
  assign wide = {mb, 26'd0} >> d;
  assign b_al = (d >= 8'd26) ? {26'd0, |mb} : {wide[49:24], |wide[23:0]};
  assign a_al = {ma, 3'b000};
  assign sub  = fa.sign ^ fb.sign;
  assign sum  = sub ? ({1'b0, a_al} - {1'b0, b_al}) : ({1'b0, a_al} + {1'b0, b_al});

  // Only a d<=1 subtraction can leave the top 24 bits empty, and then bit 2 holds
  // the result, so a count of 24 over sum[26:3] is still the exact shift.
  fpu_lzc24 u_lzc (
    .din   (sum[26:3]),
    .count (lz)
  );

  assign lim = ea - 8'd1;
  assign sh  = ({3'd0, lz} < lim) ? {3'd0, lz} : lim;

  always_comb begin
    if (sum[27]) begin
      norm  = {sum[27:2], |sum[1:0]};
      exp_n = {2'b00, ea} + 10'd1;
    end else begin
      norm  = sum[26:0] << sh;
      exp_n = {2'b00, ea} - {2'b00, sh};
    end
  end

  assign rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign mant_r = {1'b0, norm[26:3]} + {24'd0, rnd};
  assign exp_r  = exp_n + {9'd0, mant_r[24]};
  assign hid    = mant_r[24] | mant_r[23];
  assign frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

  // A result without the hidden bit can only sit at exponent 1, which encodes as 0.
  always_comb begin
    if (sum == 28'd0)
      fin = {fa.sign & fb.sign, 31'd0};
    else if (exp_r >= 10'd255)
      fin = {fa.sign, EXP_MAX, 23'd0};
    else
      fin = {fa.sign, hid ? exp_r[7:0] : 8'd0, frac};
  end

  always_comb begin
    res = fin;
    if (is_nan(f1))
      res = x1 | 32'h0040_0000;
    else if (is_nan(f2))
      res = x2 | 32'h0040_0000;
    else if (is_inf(f1) && is_inf(f2) && (f1.sign != f2.sign))
      res = CANON_NAN;
    else if (is_inf(f1))
      res = x1;
    else if (is_inf(f2))
      res = x2;
  end

  assign ovf_d = (f1.exp != EXP_MAX) && (f2.exp != EXP_MAX) && (res[30:23] == EXP_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y   <= 32'd0;
      ovf <= 1'b0;
    end else begin
      y   <= res;
      ovf <= ovf_d;
    end
  end
endmodule

// File: tb/tb_fpu_fadd.sv
// Self-checking bench for fpu_fadd: directed vectors, exact-integer reference sweep, reset.
module tb_fpu_fadd;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x1 = 32'd0;
  logic [31:0] x2 = 32'd0;
  logic [31:0] y;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        ovf;
  } sb_t;
  sb_t exp_q[$];

  logic [22:0] corners [7] = '{23'h0, 23'h1, 23'h2, 23'h380000, 23'h400000, 23'h5FFFFF, 23'h7FFFFF};

  fpu_fadd dut (
    .clk (clk),
    .rst (rst),
    .x1  (x1),
    .x2  (x2),
    .y   (y),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  // Exact reference: operands become integers in units of 2^-149, summed exactly, then rounded.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] ma, mb, m, rem, half;
    logic         s;
    logic [24:0]  mant;
    logic [31:0]  r;
    int           p, k, e, ea, eb;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return {1'b0, a | 32'h0040_0000};
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return {1'b0, b | 32'h0040_0000};
    if (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000 && a[31] != b[31])
      return {1'b0, 32'hFFC0_0000};
    if (a[30:0] == 31'h7F800000) return {1'b0, a};
    if (b[30:0] == 31'h7F800000) return {1'b0, b};
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    ma = {276'd0, a[30:23] != 8'd0, a[22:0]} << (ea - 1);
    mb = {276'd0, b[30:23] != 8'd0, b[22:0]} << (eb - 1);
    if (a[31] == b[31]) begin
      m = ma + mb; s = a[31];
    end else if (ma >= mb) begin
      m = ma - mb; s = a[31];
    end else begin
      m = mb - ma; s = b[31];
    end
    if (m == 300'd0) return {1'b0, a[31] & b[31], 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p <= 23) begin
      r = {s, (p == 23) ? 8'd1 : 8'd0, m[22:0]};
    end else begin
      k    = p - 23;
      mant = 25'(m >> k);
      rem  = m & ((300'd1 << k) - 300'd1);
      half = 300'd1 << (k - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 25'd1;
      e = p - 22;
      if (mant[24]) begin
        mant = mant >> 1;
        e++;
      end
      if (e >= 255) r = {s, 8'hFF, 23'd0};
      else          r = {s, 8'(e), mant[22:0]};
    end
    return {r[30:23] == 8'hFF, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    x1  = 32'h3F800000;
    x2  = 32'h3F800000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (y !== 32'd0) begin
      errors++; $display("FAIL reset_y got=%h exp=%h", y, 32'd0);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got=%b exp=0", ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [96:0] tv [20];
    sb_t e;
    tv = '{
      {32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0},
      {32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0},
      {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1},
      {32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1},
      {32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0},
      {32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0},
      {32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, 1'b0},
      {32'h00000001, 32'h00000001, 32'h00000002, 1'b0},
      {32'h007FFFFF, 32'h00000001, 32'h00800000, 1'b0},
      {32'h80000000, 32'h80000000, 32'h80000000, 1'b0},
      {32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b0},
      {32'h7F800001, 32'h3F800000, 32'h7FC00001, 1'b0},
      {32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 1'b0},
      {32'h00000000, 32'h80000000, 32'h00000000, 1'b0},
      {32'h3F800000, 32'hFF800001, 32'hFFC00001, 1'b0},
      {32'h7F800001, 32'hFF800002, 32'h7FC00001, 1'b0},
      {32'hBF800000, 32'h3F800000, 32'h00000000, 1'b0},
      {32'h00800000, 32'h80000001, 32'h007FFFFF, 1'b0},
      {32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0},
      {32'h4B800001, 32'h3F800000, 32'h4B800002, 1'b0}
    };
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (y !== e.y) begin
          errors++; $display("FAIL directed_y a=%h b=%h got=%h exp=%h", e.a, e.b, y, e.y);
        end
        checks++;
        if (ovf !== e.ovf) begin
          errors++; $display("FAIL directed_ovf a=%h b=%h got=%b exp=%b", e.a, e.b, ovf, e.ovf);
        end
      end
      if (n < 20) begin
        x1 = tv[n][96:65];
        x2 = tv[n][64:33];
        exp_q.push_back('{a: tv[n][96:65], b: tv[n][64:33], y: tv[n][32:1], ovf: tv[n][0]});
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  e1, e2;
    logic [3:0]  j;
    logic [1:0]  sg;
    logic [22:0] m1, m2;
    logic [32:0] r;
    int          i1, i2;
    sb_t         e;
    for (int n = 0; n <= 16384; n++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (y !== e.y) begin
          errors++; $display("FAIL sweep_y a=%h b=%h got=%h exp=%h", e.a, e.b, y, e.y);
        end
        checks++;
        if (ovf !== e.ovf) begin
          errors++; $display("FAIL sweep_ovf a=%h b=%h got=%b exp=%b", e.a, e.b, ovf, e.ovf);
        end
      end
      if (n < 16384) begin
        e1 = n[13:6];
        j  = n[5:2];
        sg = n[1:0];
        case (j)
          4'd0:  e2 = 8'd0;
          4'd1:  e2 = 8'd1;
          4'd2:  e2 = 8'd2;
          4'd3:  e2 = 8'd127;
          4'd4:  e2 = 8'd254;
          4'd5:  e2 = 8'd255;
          4'd6:  e2 = e1;
          4'd7:  e2 = e1 + 8'd1;
          4'd8:  e2 = e1 - 8'd1;
          4'd9:  e2 = e1 + 8'd2;
          4'd10: e2 = e1 - 8'd2;
          4'd11: e2 = e1 + 8'd25;
          4'd12: e2 = e1 - 8'd25;
          4'd13: e2 = e1 + 8'd26;
          4'd14: e2 = e1 - 8'd27;
          default: e2 = e1 + 8'd24;
        endcase
        i1 = (int'(e1) + int'(j) + int'(sg)) % 8;
        i2 = (i1 + 3) % 8;
        m1 = (i1 == 7) ? 23'($urandom) : corners[i1];
        m2 = (i2 == 7) ? 23'($urandom) : corners[i2];
        x1 = {sg[0], e1, m1};
        x2 = {sg[1], e2, m2};
        r  = ref_add(x1, x2);
        exp_q.push_back('{a: x1, b: x2, y: r[31:0], ovf: r[32]});
      end
    end
  endtask

  task automatic test_equal_exp();
    logic [7:0]  ex;
    logic [22:0] m1, m2, mask;
    logic [32:0] r;
    logic        s1;
    sb_t         e;
    for (int n = 0; n <= 400; n++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (y !== e.y) begin
          errors++; $display("FAIL eqexp_y a=%h b=%h got=%h exp=%h", e.a, e.b, y, e.y);
        end
        checks++;
        if (ovf !== e.ovf) begin
          errors++; $display("FAIL eqexp_ovf a=%h b=%h got=%b exp=%b", e.a, e.b, ovf, e.ovf);
        end
      end
      if (n < 400) begin
        ex   = 8'($urandom_range(0, 254));
        mask = 23'((32'd1 << $urandom_range(0, 22)) - 32'd1);
        m1   = 23'($urandom);
        m2   = (m1 & ~mask) | (23'($urandom) & mask);
        s1   = 1'($urandom);
        x1   = {s1, ex, m1};
        x2   = {(n % 4 == 0) ? s1 : ~s1, ex, m2};
        r    = ref_add(x1, x2);
        exp_q.push_back('{a: x1, b: x2, y: r[31:0], ovf: r[32]});
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    x1 = 32'h7F7FFFFF;
    x2 = 32'h7F7FFFFF;
    @(posedge clk);
    #1;
    checks++;
    if (y !== 32'h7F800000) begin
      errors++; $display("FAIL midrst_pre_y got=%h exp=%h", y, 32'h7F800000);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL midrst_pre_ovf got=%b exp=1", ovf);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (y !== 32'd0) begin
      errors++; $display("FAIL midrst_async_y got=%h exp=%h", y, 32'd0);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL midrst_async_ovf got=%b exp=0", ovf);
    end
    x1 = 32'h3F800000;
    x2 = 32'h3F800000;
    @(posedge clk);
    #1;
    checks++;
    if (y !== 32'd0) begin
      errors++; $display("FAIL midrst_hold_y got=%h exp=%h", y, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    x1  = 32'h00000001;
    x2  = 32'h00000001;
    @(posedge clk);
    #1;
    checks++;
    if (y !== 32'h00000002) begin
      errors++; $display("FAIL midrst_first_y got=%h exp=%h", y, 32'h00000002);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL midrst_first_ovf got=%b exp=0", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_equal_exp();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
